nios_onchip_memory_pipelined: RTL and testbench

NIOS_ONCHIP_MEMORY_PIPELINED -- requirements
Module: nios_onchip_memory_pipelined

---
 rtl/nios_onchip_memory_pipelined_if.sv | 31 +++
 rtl/nios_onchip_memory_pipelined.sv | 123 ++++++++++++
 tb/tb_nios_onchip_memory_pipelined.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_onchip_memory_pipelined_if.sv
// Avalon-style slave bus for the pipelined on-chip memory, with clock-enable,
// reset-pending request and init status carried alongside the handshake.
interface nios_onchip_memory_pipelined_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 15
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [BE_WIDTH-1:0]   byteenable;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  clken;
  logic                  reset_req;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  waitrequest;
  logic                  init_done;

  modport master (
    output address, byteenable, chipselect, read, write, writedata, clken, reset_req,
    input  readdata, readdatavalid, waitrequest, init_done
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata, clken, reset_req,
    output readdata, readdatavalid, waitrequest, init_done
  );
endinterface

// File: rtl/nios_onchip_memory_pipelined.sv
// Single-port on-chip RAM with byte-lane writes and a 1- or 2-cycle read pipeline.
// Optional feature macro: ONCHIP_MEM_CLEAR_EN -- zero the whole array after reset.
module nios_onchip_memory_pipelined #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  nios_onchip_memory_pipelined_if.slave bus
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned DEPTH    = 32'd1 << ADDR_WIDTH;

  typedef enum logic {INIT, READY} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  accept_c;
  logic                  wr_en_c;
  logic                  rd_en_c;
  logic                  rvalid_d, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  // Stall whenever not ready, clock-gated, or a reset is pending.
  assign bus.waitrequest = bus.reset_req | ~bus.clken | (state_q != READY);
  assign accept_c        = bus.chipselect & (bus.read | bus.write) & ~bus.waitrequest;
  // A combined read+write is a write only; nothing is accepted on a reset edge.
  assign wr_en_c         = accept_c & bus.write & ~reset;
  assign rd_en_c         = accept_c & ~bus.write & ~reset;

`ifdef ONCHIP_MEM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_en_c;

  assign clr_en_c = (state_q == INIT) & bus.clken & ~reset;

  // Clear address counter, restarted by reset.
  always_ff @(posedge clk) begin
    if (reset) clr_cnt_q <= '0;
    else       clr_cnt_q <= clr_cnt_d;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  // Next state: INIT sweeps the array (clear build) or lasts one cycle.
  always_comb begin
    state_d = state_q;
`ifdef ONCHIP_MEM_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      INIT: begin
`ifdef ONCHIP_MEM_CLEAR_EN
        if (bus.clken) begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
          if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = READY;
        end
`else
        state_d = READY;
`endif
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // Memory array: byte-lane writes, plus zero-fill while clearing.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (bus.byteenable[i]) mem[bus.address][i*8 +: 8] <= bus.writedata[i*8 +: 8];
      end
    end
`ifdef ONCHIP_MEM_CLEAR_EN
    if (clr_en_c) mem[clr_cnt_q] <= '0;
`endif
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_valid_q;
      logic [DATA_WIDTH-1:0] s1_data_q;

      // Extra read stage between the array and the output register.
      always_ff @(posedge clk) begin
        if (reset) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
        end else begin
          s1_valid_q <= rd_en_c;
          if (rd_en_c) s1_data_q <= mem[bus.address];
        end
      end

      assign rvalid_d = s1_valid_q;
      assign rdata_d  = s1_data_q;
    end else begin : g_lat1
      assign rvalid_d = rd_en_c;
      assign rdata_d  = mem[bus.address];
    end
  endgenerate

  // Output register: readdata only moves with a valid beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      if (rvalid_d) rdata_q <= rdata_d;
    end
  end

  assign bus.readdatavalid = rvalid_q;
  assign bus.readdata      = rdata_q;
  assign bus.init_done     = (state_q == READY);
endmodule

// File: tb/tb_nios_onchip_memory_pipelined.sv
// Directed bench: dut1 is READ_LATENCY=1 / 32 words, dut2 is READ_LATENCY=2 / 16 words.
module tb_nios_onchip_memory_pipelined;
`ifdef ONCHIP_MEM_CLEAR_EN
  localparam int INIT1 = 32;
  localparam int INIT2 = 16;
  localparam bit CLR   = 1'b1;
`else
  localparam int INIT1 = 1;
  localparam int INIT2 = 1;
  localparam bit CLR   = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nios_onchip_memory_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) b1 ();
  nios_onchip_memory_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b2 ();

  nios_onchip_memory_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1));
  nios_onchip_memory_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2));

  task automatic set_req(input int d, input logic rd, input logic wr, input logic [4:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    if (d == 1) begin
      b1.chipselect = 1'b1; b1.read = rd; b1.write = wr;
      b1.address = a; b1.writedata = wd; b1.byteenable = be;
    end else begin
      b2.chipselect = 1'b1; b2.read = rd; b2.write = wr;
      b2.address = a[3:0]; b2.writedata = wd; b2.byteenable = be;
    end
  endtask

  task automatic idle(input int d);
    if (d == 1) begin
      b1.chipselect = 1'b0; b1.read = 1'b0; b1.write = 1'b0;
      b1.address = '0; b1.writedata = '0; b1.byteenable = '0;
    end else begin
      b2.chipselect = 1'b0; b2.read = 1'b0; b2.write = 1'b0;
      b2.address = '0; b2.writedata = '0; b2.byteenable = '0;
    end
  endtask

  task automatic write_word(input int d, input logic [4:0] a, input logic [31:0] wd,
                            input logic [3:0] be);
    set_req(d, 1'b0, 1'b1, a, wd, be);
    @(negedge clk);
    idle(d);
  endtask

  // Releases reset and records the first cycle each DUT shows init_done.
  task automatic release_and_wait(output int n1, output int n2);
    reset = 1'b0;
    n1 = 0;
    n2 = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (b1.init_done === 1'b1 && n1 == 0) n1 = k;
      if (b2.init_done === 1'b1 && n2 == 0) n2 = k;
      if (n1 != 0 && n2 != 0) break;
    end
  endtask

  task automatic test_reset();
    int n1, n2;
    reset = 1'b1;
    idle(1); idle(2);
    b1.clken = 1'b1; b1.reset_req = 1'b0;
    b2.clken = 1'b1; b2.reset_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (b1.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b want 0", b1.readdatavalid); end
    checks++; if (b1.readdata !== 32'h0) begin errors++; $display("FAIL reset_data1 got %h want 0", b1.readdata); end
    checks++; if (b2.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_valid2 got %b want 0", b2.readdatavalid); end
    checks++; if (b2.readdata !== 32'h0) begin errors++; $display("FAIL reset_data2 got %h want 0", b2.readdata); end
    checks++; if (b1.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", b1.init_done); end
    checks++; if (b2.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitreq got %b want 1", b2.waitrequest); end
    release_and_wait(n1, n2);
    checks++; if (n1 != INIT1) begin errors++; $display("FAIL init_len1 got %0d want %0d", n1, INIT1); end
    checks++; if (n2 != INIT2) begin errors++; $display("FAIL init_len2 got %0d want %0d", n2, INIT2); end
    checks++; if (b1.waitrequest !== 1'b0) begin errors++; $display("FAIL ready_waitreq got %b want 0", b1.waitrequest); end
  endtask

  task automatic test_byte_enable();
    write_word(1, 5'h10, 32'hDEADBEEF, 4'hF);
    write_word(1, 5'h10, 32'h000000AA, 4'h1);
    write_word(1, 5'h10, 32'hFFFFFFFF, 4'h0);
    set_req(1, 1'b1, 1'b0, 5'h10, 32'h0, 4'h0);
    @(negedge clk);
    idle(1);
    checks++; if (b1.readdatavalid !== 1'b1) begin errors++; $display("FAIL be_valid got %b want 1", b1.readdatavalid); end
    checks++; if (b1.readdata !== 32'hDEADBEAA) begin errors++; $display("FAIL be_low_lane got %h want deadbeaa", b1.readdata); end
    @(negedge clk);
    checks++; if (b1.readdatavalid !== 1'b0) begin errors++; $display("FAIL be_pulse got %b want 0", b1.readdatavalid); end
    checks++; if (b1.readdata !== 32'hDEADBEAA) begin errors++; $display("FAIL be_hold got %h want deadbeaa", b1.readdata); end
    write_word(1, 5'h10, 32'h11220000, 4'hC);
    set_req(1, 1'b1, 1'b0, 5'h10, 32'h0, 4'h0);
    @(negedge clk);
    idle(1);
    checks++; if (b1.readdata !== 32'h1122BEAA) begin errors++; $display("FAIL be_high_lanes got %h want 1122beaa", b1.readdata); end
  endtask

  task automatic test_read_after_write();
    set_req(1, 1'b0, 1'b1, 5'd3, 32'hA5A50001, 4'hF);
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0);
    @(negedge clk);
    idle(1);
    checks++; if (b1.readdatavalid !== 1'b1 || b1.readdata !== 32'hA5A50001) begin
      errors++; $display("FAIL raw_lat1 got %b/%h want 1/a5a50001", b1.readdatavalid, b1.readdata); end
    set_req(2, 1'b0, 1'b1, 5'd7, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    set_req(2, 1'b1, 1'b0, 5'd7, 32'h0, 4'h0);
    @(negedge clk);
    idle(2);
    checks++; if (b2.readdatavalid !== 1'b0) begin errors++; $display("FAIL raw_lat2_early got %b want 0", b2.readdatavalid); end
    @(negedge clk);
    checks++; if (b2.readdatavalid !== 1'b1 || b2.readdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL raw_lat2 got %b/%h want 1/0badf00d", b2.readdatavalid, b2.readdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    d[0] = 32'hA0000001; d[1] = 32'hB0000002; d[2] = 32'hC0000003;
    for (int i = 0; i < 3; i++) begin
      write_word(1, 5'(i + 1), d[i], 4'hF);
      write_word(2, 5'(i + 1), d[i], 4'hF);
    end
    // Latency 1: valid on the three beats right after the accept edges.
    for (int k = 0; k < 4; k++) begin
      if (k < 3) set_req(1, 1'b1, 1'b0, 5'(k + 1), 32'h0, 4'h0); else idle(1);
      @(negedge clk);
      checks++; if (b1.readdatavalid !== (k < 3)) begin
        errors++; $display("FAIL b2b_lat1_valid beat %0d got %b want %b", k, b1.readdatavalid, (k < 3)); end
      if (k < 3) begin
        checks++; if (b1.readdata !== d[k]) begin
          errors++; $display("FAIL b2b_lat1_data beat %0d got %h want %h", k, b1.readdata, d[k]); end
      end
    end
    // Latency 2: valid for beats 1..3, data in order, then held.
    for (int k = 0; k < 5; k++) begin
      if (k < 3) set_req(2, 1'b1, 1'b0, 5'(k + 1), 32'h0, 4'h0); else idle(2);
      @(negedge clk);
      checks++; if (b2.readdatavalid !== (k >= 1 && k <= 3)) begin
        errors++; $display("FAIL b2b_lat2_valid beat %0d got %b want %b", k, b2.readdatavalid, (k >= 1 && k <= 3)); end
      if (k >= 1) begin
        checks++; if (b2.readdata !== d[(k > 3) ? 2 : k - 1]) begin
          errors++; $display("FAIL b2b_lat2_data beat %0d got %h want %h", k, b2.readdata, d[(k > 3) ? 2 : k - 1]); end
      end
    end
  endtask

  task automatic test_stall();
    set_req(2, 1'b1, 1'b0, 5'd2, 32'h0, 4'h0);
    @(negedge clk);
    b2.clken = 1'b0;
    set_req(2, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0);
    #1;
    checks++; if (b2.waitrequest !== 1'b1) begin errors++; $display("FAIL clken_waitreq got %b want 1", b2.waitrequest); end
    @(negedge clk);
    checks++; if (b2.readdatavalid !== 1'b1 || b2.readdata !== 32'hB0000002) begin
      errors++; $display("FAIL clken_inflight got %b/%h want 1/b0000002", b2.readdatavalid, b2.readdata); end
    @(negedge clk);
    checks++; if (b2.readdatavalid !== 1'b0) begin errors++; $display("FAIL clken_no_accept got %b want 0", b2.readdatavalid); end
    @(negedge clk);
    checks++; if (b2.readdatavalid !== 1'b0) begin errors++; $display("FAIL clken_no_accept2 got %b want 0", b2.readdatavalid); end
    b2.clken = 1'b1;
    idle(2);
    b1.reset_req = 1'b1;
    set_req(1, 1'b1, 1'b0, 5'd1, 32'h0, 4'h0);
    #1;
    checks++; if (b1.waitrequest !== 1'b1) begin errors++; $display("FAIL rreq_waitreq got %b want 1", b1.waitrequest); end
    @(negedge clk);
    checks++; if (b1.readdatavalid !== 1'b0) begin errors++; $display("FAIL rreq_no_accept got %b want 0", b1.readdatavalid); end
    b1.reset_req = 1'b0;
    idle(1);
    @(negedge clk);
  endtask

  task automatic test_rw_both();
    set_req(1, 1'b1, 1'b1, 5'd5, 32'h12345678, 4'hF);
    @(negedge clk);
    idle(1);
    checks++; if (b1.readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_no_valid got %b want 0", b1.readdatavalid); end
    set_req(1, 1'b1, 1'b0, 5'd5, 32'h0, 4'h0);
    @(negedge clk);
    idle(1);
    checks++; if (b1.readdatavalid !== 1'b1 || b1.readdata !== 32'h12345678) begin
      errors++; $display("FAIL rw_written got %b/%h want 1/12345678", b1.readdatavalid, b1.readdata); end
  endtask

  task automatic test_reset_inflight();
    int n1, n2;
    logic [31:0] exp2, exp1;
    exp2 = CLR ? 32'h0 : 32'hC0000003;
    exp1 = CLR ? 32'h0 : 32'h1122BEAA;
    set_req(2, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0);
    @(negedge clk);
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (b2.readdatavalid !== 1'b0 || b2.readdata !== 32'h0) begin
      errors++; $display("FAIL rst_inflight got %b/%h want 0/0", b2.readdatavalid, b2.readdata); end
    @(negedge clk);
    checks++; if (b2.readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_discard got %b want 0", b2.readdatavalid); end
    release_and_wait(n1, n2);
    checks++; if (b2.readdatavalid !== 1'b0 || n2 != INIT2) begin
      errors++; $display("FAIL rst_rerelease got %b/%0d want 0/%0d", b2.readdatavalid, n2, INIT2); end
    set_req(2, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 5'h10, 32'h0, 4'h0);
    @(negedge clk);
    idle(2); idle(1);
    checks++; if (b1.readdata !== exp1) begin errors++; $display("FAIL rst_mem1 got %h want %h", b1.readdata, exp1); end
    @(negedge clk);
    checks++; if (b2.readdatavalid !== 1'b1 || b2.readdata !== exp2) begin
      errors++; $display("FAIL rst_mem2 got %b/%h want 1/%h", b2.readdatavalid, b2.readdata, exp2); end
  endtask

`ifdef ONCHIP_MEM_CLEAR_EN
  task automatic test_clear();
    int n1, n2;
    for (int a = 0; a < 16; a++) write_word(2, 5'(a), 32'h55555555, 4'hF);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    release_and_wait(n1, n2);
    checks++; if (n2 != 16) begin errors++; $display("FAIL clear_len got %0d want 16", n2); end
    for (int k = 0; k < 18; k++) begin
      if (k < 16) set_req(2, 1'b1, 1'b0, 5'(k), 32'h0, 4'h0); else idle(2);
      @(negedge clk);
      if (k >= 1 && k <= 16) begin
        checks++; if (b2.readdatavalid !== 1'b1 || b2.readdata !== 32'h0) begin
          errors++; $display("FAIL clear_data addr %0d got %b/%h want 1/0", k - 1, b2.readdatavalid, b2.readdata); end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte_enable();
    test_read_after_write();
    test_back_to_back();
    test_stall();
    test_rw_both();
    test_reset_inflight();
`ifdef ONCHIP_MEM_CLEAR_EN
    test_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
